// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU selects, FSM states
// and instruction field positions.
package control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_XOR   = 4'd8
    } opcode_e;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LOADIR  = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    // Which datapath write an instruction performs in EXECUTE
    typedef enum logic [1:0] {
        WR_NONE,
        WR_DMEM,
        WR_RFA,
        WR_RFB
    } wr_class_e;

    localparam int unsigned OP_MSB       = 15;
    localparam int unsigned OP_LSB       = 12;
    localparam int unsigned MEM_ADDR_MSB = 11;
    localparam int unsigned MEM_ADDR_LSB = 4;
    localparam int unsigned MEM_REG_MSB  = 3;
    localparam int unsigned MEM_REG_LSB  = 0;
    localparam int unsigned ALU_RA_MSB   = 11;
    localparam int unsigned ALU_RA_LSB   = 8;
    localparam int unsigned ALU_RB_MSB   = 7;
    localparam int unsigned ALU_RB_LSB   = 4;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Combinational instruction decode: IR -> datapath addresses, ALU select,
// write class and halt flag.
module instr_decoder
    import control_unit_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [7:0]  d_addr_o,
    output logic [3:0]  rf_a_addr_o,
    output logic [3:0]  rf_b_addr_o,
    output logic [2:0]  alu_s_o,
    output wr_class_e   wr_class_o,
    output logic        halt_o
);

    opcode_e op;
    assign op = opcode_e'(ir_i[OP_MSB:OP_LSB]);

    always_comb begin
        d_addr_o    = '0;
        rf_a_addr_o = '0;
        rf_b_addr_o = '0;
        wr_class_o  = WR_NONE;
        halt_o      = 1'b0;
        case (op)
            OP_STORE, OP_LOAD: begin
                d_addr_o    = ir_i[MEM_ADDR_MSB:MEM_ADDR_LSB];
                rf_a_addr_o = ir_i[MEM_REG_MSB:MEM_REG_LSB];
                wr_class_o  = (op == OP_STORE) ? WR_DMEM : WR_RFA;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rf_a_addr_o = ir_i[ALU_RA_MSB:ALU_RA_LSB];
                rf_b_addr_o = ir_i[ALU_RB_MSB:ALU_RB_LSB];
                wr_class_o  = WR_RFB;
            end
            OP_HALT: halt_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_s_o = ALU_ADD;
            OP_SUB:  alu_s_o = ALU_SUB;
            OP_AND:  alu_s_o = ALU_AND;
            OP_OR:   alu_s_o = ALU_OR;
            OP_XOR:  alu_s_o = ALU_XOR;
            default: alu_s_o = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: FETCH -> LOADIR -> DECODE -> EXECUTE, with an
// absorbing HALT state. Owns PC, IR and the state register.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned PC_W       = 7,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] I_addr,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic [3:0]      RF_A_addr,
    output logic [3:0]      RF_B_addr,
    output logic            RF_WenA,
    output logic            RF_WenB,
    output logic [2:0]      ALU_s,
    output logic [15:0]     IR,
    output logic [2:0]      State,
    output logic            Halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    wr_class_e       wr_class;
    logic            dec_halt;

    instr_decoder u_dec (
        .ir_i        (ir_q),
        .d_addr_o    (D_addr),
        .rf_a_addr_o (RF_A_addr),
        .rf_b_addr_o (RF_B_addr),
        .alu_s_o     (ALU_s),
        .wr_class_o  (wr_class),
        .halt_o      (dec_halt)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_W'(START_ADDR);
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Write enables come only from EXECUTE, so they fall with the async reset
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        D_wr    = 1'b0;
        RF_WenA = 1'b0;
        RF_WenB = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_LOADIR;
            S_LOADIR: begin
                ir_d    = I_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: state_d = dec_halt ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                D_wr    = (wr_class == WR_DMEM);
                RF_WenA = (wr_class == WR_RFA);
                RF_WenB = (wr_class == WR_RFB);
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    assign I_addr = pc_q;
    assign IR     = ir_q;
    assign State  = state_q;
    assign Halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// programs checked against an instruction-level reference model.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] I_data = '0;
    logic [6:0]  I_addr;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [3:0]  RF_A_addr, RF_B_addr;
    logic        RF_WenA, RF_WenB;
    logic [2:0]  ALU_s;
    logic [15:0] IR;
    logic [2:0]  State;
    logic        Halted;

    logic [15:0] I_data2 = '0;
    logic [1:0]  I_addr2;
    logic [7:0]  D_addr2;
    logic        D_wr2;
    logic [3:0]  RF_A_addr2, RF_B_addr2;
    logic        RF_WenA2, RF_WenB2;
    logic [2:0]  ALU_s2;
    logic [15:0] IR2;
    logic [2:0]  State2;
    logic        Halted2;

    logic [15:0] rom [128];
    int tests = 0;
    int fails = 0;

    control_unit #(.PC_W(7), .START_ADDR(0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .I_data(I_data), .I_addr(I_addr),
        .D_addr(D_addr), .D_wr(D_wr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .RF_WenA(RF_WenA), .RF_WenB(RF_WenB), .ALU_s(ALU_s), .IR(IR),
        .State(State), .Halted(Halted)
    );

    control_unit #(.PC_W(2), .START_ADDR(0)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .I_data(I_data2), .I_addr(I_addr2),
        .D_addr(D_addr2), .D_wr(D_wr2), .RF_A_addr(RF_A_addr2), .RF_B_addr(RF_B_addr2),
        .RF_WenA(RF_WenA2), .RF_WenB(RF_WenB2), .ALU_s(ALU_s2), .IR(IR2),
        .State(State2), .Halted(Halted2)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction ROM: data valid the cycle after the address
    always @(posedge Clk) I_data <= rom[I_addr];

    function automatic logic [48:0] obs();
        return {State, I_addr, IR, D_addr, RF_A_addr, RF_B_addr,
                RF_WenA, RF_WenB, D_wr, ALU_s, Halted};
    endfunction

    // Expected outputs given the phase of the instruction cycle, PC and IR
    function automatic logic [48:0] expv(input int st, input int pc, input logic [15:0] ir);
        logic [3:0] op;
        logic [7:0] da;
        logic [3:0] ra, rb;
        logic [2:0] alu;
        logic       wa, wb, dw, is_alu;
        op = ir[15:12];
        da = '0; ra = '0; rb = '0; alu = '0; wa = 1'b0; wb = 1'b0; dw = 1'b0;
        is_alu = (op == 4'd3 || op == 4'd4 || op == 4'd6 || op == 4'd7 || op == 4'd8);
        if (op == 4'd1 || op == 4'd2) begin
            da = ir[11:4];
            ra = ir[3:0];
        end else if (is_alu) begin
            ra = ir[11:8];
            rb = ir[7:4];
        end
        case (op)
            4'd3: alu = 3'b011;
            4'd4: alu = 3'b010;
            4'd6: alu = 3'b110;
            4'd7: alu = 3'b101;
            4'd8: alu = 3'b100;
            default: alu = 3'b000;
        endcase
        if (st == 3) begin
            dw = (op == 4'd1);
            wa = (op == 4'd2);
            wb = is_alu;
        end
        return {3'(st), 7'(pc), ir, da, ra, rb, wa, wb, dw, alu, (st == 4)};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        do op = 4'($urandom_range(0, 15)); while (op == 4'd5);
        return {op, 12'($urandom)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Leaves the bench at a falling edge with the DUT in its first FETCH cycle
    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 128; i++) rom[i] = rand_instr();
        do_reset();
        repeat ($urandom_range(5, 14)) tick();
        Reset_n = 1'b0;
        #1;
        tests++;
        if (obs() !== expv(0, 0, 16'h0)) begin
            $display("FAIL reset_state: got %h expected %h", obs(), expv(0, 0, 16'h0));
            fails++;
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_load();
        clear_rom();
        rom[0] = 16'h2053;
        do_reset();
        repeat (3) tick();
        tests++;
        if ({RF_WenA, RF_WenB, D_wr, D_addr, RF_A_addr, RF_B_addr, I_addr, State}
            !== {1'b1, 1'b0, 1'b0, 8'h05, 4'd3, 4'd0, 7'd1, 3'd3}) begin
            $display("FAIL load_execute: wa=%b wb=%b dw=%b da=%h ra=%h rb=%h pc=%0d st=%0d required 1 0 0 05 3 0 1 3",
                     RF_WenA, RF_WenB, D_wr, D_addr, RF_A_addr, RF_B_addr, I_addr, State);
            fails++;
        end
    endtask

    task automatic test_add();
        int wb_cycles;
        clear_rom();
        rom[0] = 16'h3120;
        do_reset();
        wb_cycles = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (RF_WenB === 1'b1) wb_cycles++;
            if (cyc == 4) begin
                tests++;
                if ({ALU_s, RF_A_addr, RF_B_addr, RF_WenB, RF_WenA, D_wr}
                    !== {3'b011, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0}) begin
                    $display("FAIL add_execute: alu=%b ra=%h rb=%h wb=%b wa=%b dw=%b required 011 1 2 1 0 0",
                             ALU_s, RF_A_addr, RF_B_addr, RF_WenB, RF_WenA, D_wr);
                    fails++;
                end
            end
            tick();
        end
        tests++;
        if (wb_cycles != 1) begin
            $display("FAIL add_wenb_width: got %0d cycles required 1", wb_cycles);
            fails++;
        end
    endtask

    task automatic test_store();
        int dw_cycles;
        clear_rom();
        rom[0] = 16'h1407;
        do_reset();
        dw_cycles = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (D_wr === 1'b1 && cyc != 4) dw_cycles++;
            if (cyc == 4) begin
                tests++;
                if ({D_wr, D_addr, RF_A_addr, RF_WenA, RF_WenB}
                    !== {1'b1, 8'h40, 4'd7, 1'b0, 1'b0}) begin
                    $display("FAIL store_execute: dw=%b da=%h ra=%h wa=%b wb=%b required 1 40 7 0 0",
                             D_wr, D_addr, RF_A_addr, RF_WenA, RF_WenB);
                    fails++;
                end
            end
            tick();
        end
        tests++;
        if (dw_cycles != 0) begin
            $display("FAIL store_dwr_outside_execute: got %0d cycles required 0", dw_cycles);
            fails++;
        end
    endtask

    task automatic test_noop_halt();
        clear_rom();
        rom[0] = 16'h0000;
        rom[1] = 16'hF000;
        rom[2] = 16'h5000;
        do_reset();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tests++;
            if ({RF_WenA, RF_WenB, D_wr} !== 3'b000) begin
                $display("FAIL halt_prog_wen cycle %0d: got %b required 000", cyc, {RF_WenA, RF_WenB, D_wr});
                fails++;
            end
            if (cyc >= 12) begin
                tests++;
                if ({Halted, State, I_addr, IR} !== {1'b1, 3'd4, 7'd3, 16'h5000}) begin
                    $display("FAIL halt_hold cycle %0d: halted=%b st=%0d pc=%0d ir=%h required 1 4 3 5000",
                             cyc, Halted, State, I_addr, IR);
                    fails++;
                end
            end else if (Halted !== 1'b0) begin
                tests++;
                $display("FAIL halt_early cycle %0d: got 1 required 0", cyc);
                fails++;
            end
            tick();
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        for (int cyc = 1; cyc <= 17; cyc++) begin
            if (cyc % 4 == 1) begin
                tests++;
                if ({State2, I_addr2} !== {3'd0, 2'((cyc - 1) / 4)}) begin
                    $display("FAIL pc_wrap cycle %0d: st=%0d pc=%0d required 0 %0d",
                             cyc, State2, I_addr2, ((cyc - 1) / 4) % 4);
                    fails++;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_execute();
        clear_rom();
        rom[0] = 16'h3120;
        do_reset();
        repeat (3) tick();
        tests++;
        if (RF_WenB !== 1'b1) begin
            $display("FAIL mid_exec_pre: wb=%b required 1", RF_WenB);
            fails++;
        end
        #1;
        Reset_n = 1'b0;
        #1;
        tests++;
        if ({RF_WenB, State, I_addr, IR, ALU_s} !== '0) begin
            $display("FAIL mid_exec_async: wb=%b st=%0d pc=%0d ir=%h alu=%b required all 0",
                     RF_WenB, State, I_addr, IR, ALU_s);
            fails++;
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        tests++;
        if ({State, I_addr} !== {3'd0, 7'd0}) begin
            $display("FAIL mid_exec_release: st=%0d pc=%0d required 0 0", State, I_addr);
            fails++;
        end
        repeat (3) tick();
        tests++;
        if ({State, RF_WenB} !== {3'd3, 1'b1}) begin
            $display("FAIL mid_exec_rerun: st=%0d wb=%b required 3 1", State, RF_WenB);
            fails++;
        end
    endtask

    // Instruction-level model: each instruction is fetched from rom[pc],
    // visible in IR from DECODE, and performs its write in EXECUTE.
    task automatic test_random(input bit with_halt, input int n_instr);
        int pc;
        logic [15:0] ir;
        bit stop;
        for (int i = 0; i < 128; i++) rom[i] = rand_instr();
        if (with_halt) rom[$urandom_range(3, 30)] = {4'd5, 12'($urandom)};
        do_reset();
        pc = 0;
        ir = 16'h0;
        stop = 1'b0;
        for (int k = 0; k < n_instr && !stop; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
                if (ph == 2) begin
                    ir = rom[pc];
                    pc = (pc + 1) % 128;
                end
                if (ph == 3 && ir[15:12] == 4'd5) begin
                    for (int h = 0; h < 20; h++) begin
                        tests++;
                        if (obs() !== expv(4, pc, ir)) begin
                            $display("FAIL rand_halt instr %0d: got %h expected %h", k, obs(), expv(4, pc, ir));
                            fails++;
                        end
                        tick();
                    end
                    stop = 1'b1;
                    break;
                end
                tests++;
                if (obs() !== expv(ph, pc, ir)) begin
                    $display("FAIL rand_prog instr %0d phase %0d: got %h expected %h",
                             k, ph, obs(), expv(ph, pc, ir));
                    fails++;
                end
                tick();
            end
        end
        if (with_halt) begin
            tests++;
            if (!stop) begin
                $display("FAIL rand_halt_reached: got 0 required 1");
                fails++;
            end
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_load();
        test_add();
        test_store();
        test_noop_halt();
        test_pc_wrap();
        test_reset_mid_execute();
        test_random(1'b0, 132);
        test_random(1'b1, 40);
        test_random(1'b1, 40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
